psr_bank_ctrl: RTL and testbench

Holds the ARM CPSR and the five banked SPSRs and runs the status-register side of exception entry and return. Exception entry saves CPSR into the SPSR of the target mode. Exception return restores CPSR from the current mode's SPSR. It sits beside the register file, driving the current mode and the current-mode SPSR index, and serves the execute stage's MSR/MRS and flag-writeback paths.

---
 rtl/psr_bank_ctrl.sv | 175 +++++++++++++++++
 tb/tb_psr_bank_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/psr_bank_ctrl.sv
// CPSR plus five banked SPSRs, sequencing the status-register side of
// exception entry/return and serving MSR and condition-flag writeback.
module psr_bank_ctrl #(
    parameter logic [31:0] VEC_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_req,
    input  logic [2:0]  exc_type,
    input  logic        ret_req,
    input  logic        msr_we,
    input  logic        msr_spsr,
    input  logic [3:0]  msr_mask,
    input  logic [31:0] msr_data,
    input  logic        flag_we,
    input  logic [3:0]  flag_nzcv,
    output logic [31:0] cpsr,
    output logic [31:0] spsr,
    output logic [4:0]  mode,
    output logic [2:0]  spsr_idx,
    output logic [31:0] vector,
    output logic        exc_ack,
    output logic        ret_done,
    output logic        ret_err,
    output logic        busy
);
    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;

    typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_VECT, S_RET} state_t;

    state_t      r_state;
    logic [31:0] r_cpsr;
    logic [31:0] r_spsr [1:5];
    logic [2:0]  r_type;
    logic [31:0] r_vector;
    logic        r_exc_ack;
    logic        r_ret_done;
    logic        r_ret_err;

    logic [2:0]  w_idx;
    logic [4:0]  w_tgt_mode;
    logic [2:0]  w_tgt_idx;
    logic [31:0] w_spsr_cur;
    logic [3:0]  w_cpsr_mask;
    logic        w_exc_ok;

    function automatic logic [2:0] f_mode_idx(input logic [4:0] m);
        case (m)
            MODE_FIQ: return 3'd1;
            MODE_SVC: return 3'd2;
            MODE_ABT: return 3'd3;
            MODE_IRQ: return 3'd4;
            MODE_UND: return 3'd5;
            default:  return 3'd0;
        endcase
    endfunction

    function automatic logic [4:0] f_type_mode(input logic [2:0] t);
        case (t)
            3'd1:       return MODE_UND;
            3'd2:       return MODE_SVC;
            3'd3, 3'd4: return MODE_ABT;
            3'd5:       return MODE_IRQ;
            3'd6:       return MODE_FIQ;
            default:    return MODE_USR;
        endcase
    endfunction

    function automatic logic [31:0] f_type_off(input logic [2:0] t);
        case (t)
            3'd1:    return 32'h04;
            3'd2:    return 32'h08;
            3'd3:    return 32'h0C;
            3'd4:    return 32'h10;
            3'd5:    return 32'h18;
            3'd6:    return 32'h1C;
            default: return 32'h00;
        endcase
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  mask);
        logic [31:0] res;
        res = old_v;
        for (int unsigned b = 0; b < 4; b++)
            if (mask[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        return res;
    endfunction

    assign w_idx       = f_mode_idx(r_cpsr[4:0]);
    assign w_tgt_mode  = f_type_mode(r_type);
    assign w_tgt_idx   = f_mode_idx(w_tgt_mode);
    assign w_exc_ok    = exc_req && (exc_type != 3'd0) && (exc_type != 3'd7);
    // User mode may only touch the flag byte of CPSR.
    assign w_cpsr_mask = (r_cpsr[4:0] == MODE_USR) ? {msr_mask[3], 3'b000} : msr_mask;

    always_comb begin
        w_spsr_cur = '0;
        if (w_idx != 3'd0) w_spsr_cur = r_spsr[w_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cpsr     <= 32'h0000_00D3;
            for (int unsigned i = 1; i <= 5; i++) r_spsr[i] <= '0;
            r_type     <= '0;
            r_vector   <= '0;
            r_exc_ack  <= 1'b0;
            r_ret_done <= 1'b0;
            r_ret_err  <= 1'b0;
        end else begin
            r_exc_ack  <= 1'b0;
            r_ret_done <= 1'b0;
            r_ret_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_exc_ok) begin
                        r_type  <= exc_type;
                        r_state <= S_ENTRY;
                    end else if (ret_req) begin
                        r_state <= S_RET;
                    end else if (msr_we) begin
                        if (!msr_spsr)
                            r_cpsr <= f_merge(r_cpsr, msr_data, w_cpsr_mask);
                        else if (w_idx != 3'd0)
                            r_spsr[w_idx] <= f_merge(w_spsr_cur, msr_data, msr_mask);
                    end else if (flag_we) begin
                        r_cpsr[31:28] <= flag_nzcv;
                    end
                end
                S_ENTRY: begin
                    r_spsr[w_tgt_idx] <= r_cpsr;
                    r_cpsr[4:0]       <= w_tgt_mode;
                    r_cpsr[5]         <= 1'b0;
                    r_cpsr[7]         <= 1'b1;
                    if (w_tgt_mode == MODE_FIQ) r_cpsr[6] <= 1'b1;
                    r_vector  <= VEC_BASE + f_type_off(r_type);
                    r_exc_ack <= 1'b1;
                    r_state   <= S_VECT;
                end
                S_VECT: begin
                    r_vector <= '0;
                    r_state  <= S_IDLE;
                end
                S_RET: begin
                    if (w_idx == 3'd0) begin
                        r_ret_err <= 1'b1;
                    end else begin
                        r_cpsr     <= w_spsr_cur;
                        r_ret_done <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cpsr     = r_cpsr;
    assign spsr     = w_spsr_cur;
    assign mode     = r_cpsr[4:0];
    assign spsr_idx = w_idx;
    assign vector   = r_vector;
    assign exc_ack  = r_exc_ack;
    assign ret_done = r_ret_done;
    assign ret_err  = r_ret_err;
    assign busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_psr_bank_ctrl.sv
// Scoreboard bench: stimulus queues expected entry/return results, a monitor
// pops and compares them whenever exc_ack/ret_done/ret_err pulses.
module tb_psr_bank_ctrl;
    logic        clk, rst;
    logic        exc_req, ret_req, msr_we, msr_spsr, flag_we;
    logic [2:0]  exc_type;
    logic [3:0]  msr_mask, flag_nzcv;
    logic [31:0] msr_data;
    logic [31:0] cpsr, spsr, vector;
    logic [4:0]  mode;
    logic [2:0]  spsr_idx;
    logic        exc_ack, ret_done, ret_err, busy;

    typedef struct {
        logic [1:0]  kind;   // 0 ack, 1 done, 2 err
        logic [31:0] cpsr;
        logic [31:0] spsr;
        logic [31:0] vec;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    psr_bank_ctrl #(.VEC_BASE(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .exc_req(exc_req), .exc_type(exc_type),
        .ret_req(ret_req), .msr_we(msr_we), .msr_spsr(msr_spsr),
        .msr_mask(msr_mask), .msr_data(msr_data), .flag_we(flag_we),
        .flag_nzcv(flag_nzcv), .cpsr(cpsr), .spsr(spsr), .mode(mode),
        .spsr_idx(spsr_idx), .vector(vector), .exc_ack(exc_ack),
        .ret_done(ret_done), .ret_err(ret_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        else
            n_pass++;
    endtask

    logic [1:0] mon_k;
    exp_t       mon_e;
    always @(negedge clk) begin
        if (!rst && (exc_ack || ret_done || ret_err)) begin
            mon_k = exc_ack ? 2'd0 : (ret_done ? 2'd1 : 2'd2);
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_pulse: got kind %0d expected none", mon_k);
            end else begin
                mon_e = q.pop_front();
                chk("sb_kind", {30'b0, mon_k}, {30'b0, mon_e.kind});
                chk("sb_cpsr", cpsr, mon_e.cpsr);
                chk("sb_spsr", spsr, mon_e.spsr);
                if (mon_e.kind == 2'd0) chk("sb_vector", vector, mon_e.vec);
            end
        end
    end

    task automatic do_msr(input logic sp, input logic [3:0] m, input logic [31:0] d);
        msr_we = 1'b1; msr_spsr = sp; msr_mask = m; msr_data = d;
        @(negedge clk);
        msr_we = 1'b0;
    endtask

    task automatic do_exc(input logic [2:0] t, input logic [31:0] ec, input logic [31:0] es,
                          input logic [31:0] ev, input logic side_rf, input logic side_msr);
        int n;
        q.push_back('{2'd0, ec, es, ev});
        exc_type = t; exc_req = 1'b1;
        ret_req = side_rf; flag_we = side_rf; flag_nzcv = 4'hF;
        @(negedge clk);
        ret_req = 1'b0; flag_we = 1'b0;
        if (side_msr) begin
            msr_we = 1'b1; msr_spsr = 1'b0; msr_mask = 4'hF; msr_data = 32'h0;
        end
        n = 1;
        while (!exc_ack && n < 10) begin
            @(negedge clk);
            msr_we = 1'b0;
            n++;
        end
        if (!exc_ack) chk("exc_ack_timeout", {31'b0, exc_ack}, 32'd1);
        else chk("exc_latency", n, 32'd2);
        exc_req = 1'b0; msr_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_ret(input logic [1:0] k, input logic [31:0] ec, input logic [31:0] es,
                          input logic side_msr);
        int n;
        q.push_back('{k, ec, es, 32'h0});
        ret_req = 1'b1;
        if (side_msr) begin
            msr_we = 1'b1; msr_spsr = 1'b1; msr_mask = 4'h8; msr_data = 32'hF000_0000;
        end
        @(negedge clk);
        msr_we = 1'b0;
        n = 1;
        while (!(ret_done || ret_err) && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!(ret_done || ret_err)) chk("ret_timeout", {31'b0, ret_done}, 32'd1);
        else chk("ret_latency", n, 32'd2);
        ret_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; exc_req = 1'b0; exc_type = 3'd0; ret_req = 1'b0;
        msr_we = 1'b0; msr_spsr = 1'b0; msr_mask = 4'h0; msr_data = 32'h0;
        flag_we = 1'b0; flag_nzcv = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cpsr", cpsr, 32'h0000_00D3);
        chk("rst_mode", {27'b0, mode}, 32'h13);
        chk("rst_idx", {29'b0, spsr_idx}, 32'd2);
        chk("rst_spsr", spsr, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_vector", vector, 32'h0);

        do_msr(1'b0, 4'b0001, 32'h0000_0010);
        chk("msr_to_usr", cpsr, 32'h0000_0010);
        chk("usr_idx", {29'b0, spsr_idx}, 32'd0);

        do_exc(3'd2, 32'h0000_0093, 32'h0000_0010, 32'h08, 1'b0, 1'b0);
        do_ret(2'd1, 32'h0000_0010, 32'h0, 1'b0);
        do_ret(2'd2, 32'h0000_0010, 32'h0, 1'b0);

        do_msr(1'b0, 4'hF, 32'hF000_00DF);
        chk("usr_msr_fonly", cpsr, 32'hF000_0010);
        flag_we = 1'b1; flag_nzcv = 4'b0101;
        @(negedge clk);
        flag_we = 1'b0;
        chk("flag_wb", cpsr, 32'h5000_0010);

        do_exc(3'd5, 32'h5000_0092, 32'h5000_0010, 32'h18, 1'b0, 1'b0);
        do_exc(3'd6, 32'h5000_00D1, 32'h5000_0092, 32'h1C, 1'b0, 1'b0);
        do_ret(2'd1, 32'h5000_0092, 32'h5000_0010, 1'b0);
        do_ret(2'd1, 32'h5000_0010, 32'h0, 1'b0);

        do_exc(3'd1, 32'h5000_009B, 32'h5000_0010, 32'h04, 1'b1, 1'b0);
        chk("prio_idle", {31'b0, busy}, 32'd0);
        do_exc(3'd5, 32'h5000_0092, 32'h5000_009B, 32'h18, 1'b0, 1'b1);
        chk("busy_msr_drop", cpsr, 32'h5000_0092);

        do_msr(1'b1, 4'b0011, 32'hAAAA_1234);
        chk("msr_spsr", spsr, 32'h5000_1234);
        do_msr(1'b0, 4'b1000, 32'h2000_0000);
        chk("msr_cpsr_priv", cpsr, 32'h2000_0092);
        do_exc(3'd5, 32'h2000_0092, 32'h2000_0092, 32'h18, 1'b0, 1'b0);

        exc_req = 1'b1; exc_type = 3'd0;
        repeat (3) @(negedge clk);
        chk("illegal0_busy", {31'b0, busy}, 32'd0);
        exc_type = 3'd7;
        repeat (3) @(negedge clk);
        chk("illegal7_busy", {31'b0, busy}, 32'd0);
        exc_req = 1'b0;
        chk("illegal_cpsr", cpsr, 32'h2000_0092);

        do_msr(1'b0, 4'b1000, 32'h8000_0000);
        chk("msr_flags", cpsr, 32'h8000_0092);
        do_ret(2'd1, 32'h2000_0092, 32'h2000_0092, 1'b1);

        exc_type = 3'd6; exc_req = 1'b1;
        @(negedge clk);
        chk("entry_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_cpsr", cpsr, 32'h0000_00D3);
        @(negedge clk);
        exc_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_cpsr", cpsr, 32'h0000_00D3);
        chk("rst2_spsr", spsr, 32'h0);
        chk("rst2_ack", {31'b0, exc_ack}, 32'd0);
        chk("rst2_busy", {31'b0, busy}, 32'd0);
        do_msr(1'b0, 4'b0001, 32'h0000_00D2);
        chk("irq_idx", {29'b0, spsr_idx}, 32'd4);
        chk("rst_spsr_irq", spsr, 32'h0);

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
